// File: rtl/bcd_serial_converter.sv
// Serial signed binary-to-BCD converter.
// It uses iterative double-dabble and handles one input bit per clock.
// A two's-complement word is sampled on start. Its magnitude is shifted MSB-first
// into a 10-digit BCD accumulator through a single add-3/shift slice.
// After WIDTH shift cycles, the low DIGITS digits, an overflow flag and the sign
// are published for one DONE cycle. They are then held until the next result.
module bcd_serial_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ACC_DIGITS = 10;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CW         = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   mag_in;
    logic [CW-1:0]      count;
    logic               sign_pend;

    // Unsigned magnitude of the incoming word; the most negative value wraps to 2^(WIDTH-1).
    assign mag_in = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

    // Double-dabble slice: correct every digit >= 5, then shift the next magnitude bit in.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[ACC_W-2:0], mag[WIDTH-1]};
    end

    // Next-state logic; a new request is taken in IDLE or straight out of DONE.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath.
    // Results are loaded on the final shift edge so they are valid throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mag       <= '0;
            count     <= '0;
            sign_pend <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                mag       <= mag_in;
                acc       <= '0;
                count     <= CW'(WIDTH - 1);
                sign_pend <= value[WIDTH-1];
            end else if (state == SHIFT) begin
                acc <= acc_shift;
                mag <= {mag[WIDTH-2:0], 1'b0};
                if (count == '0) begin
                    bcd <= acc_shift[4*DIGITS-1:0];
                    ovf <= |(acc_shift >> (4 * DIGITS));
                    neg <= sign_pend;
                end else begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Testbench for bcd_serial_converter (WIDTH=32, DIGITS=7).
// A driver issues random and directed requests and predicts each result with plain arithmetic.
// A monitor compares every done pulse, the held outputs and busy against that prediction.
module tb_bcd_serial_converter;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 7;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                neg;
        logic                ovf;
        int                  due;
    } exp_t;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [WIDTH-1:0]    value = '0;
    logic                busy;
    logic                done;
    logic                neg;
    logic                ovf;
    logic [4*DIGITS-1:0] bcd;

    int   cyc       = 0;
    int   next_free = 0;
    int   last_acc  = -100;
    int   prev_acc  = -100;
    int   n_acc     = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    exp_t q[$];

    logic [4*DIGITS-1:0] held_bcd = '0;
    logic                held_neg = 1'b0;
    logic                held_ovf = 1'b0;

    bcd_serial_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .neg   (neg),
        .ovf   (ovf),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Reference: decimal digits of the two's-complement magnitude, using plain division.
    function automatic exp_t model(input logic [WIDTH-1:0] v, input int due);
        exp_t           e;
        longint         mag;
        longint         tmp;
        mag = v[WIDTH-1] ? ((longint'(1) << WIDTH) - longint'(v)) : longint'(v);
        e.neg = v[WIDTH-1];
        e.ovf = (mag >= 64'd10_000_000);
        e.bcd = '0;
        tmp   = mag;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
        end
        e.due = due;
        return e;
    endfunction

    // Drive one cycle of inputs for the next edge and record the predicted acceptance.
    task automatic drive(input logic s, input logic [WIDTH-1:0] v);
        @(posedge clk);
        #1;
        start = s;
        value = v;
        if (s && rst_n && (cyc + 1) >= next_free) begin
            q.push_back(model(v, cyc + 1 + WIDTH));
            prev_acc  = last_acc;
            last_acc  = cyc + 1;
            next_free = cyc + 2 + WIDTH;
            n_acc++;
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] v);
        drive(1'b1, v);
        while ((cyc + 1) < next_free) drive(1'b0, $urandom);
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        start     = 1'b0;
        prev_acc  = -100;
        last_acc  = -100;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        next_free = 0;
    endtask

    // Monitor: checks away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_bcd = '0;
            held_neg = 1'b0;
            held_ovf = 1'b0;
            check("reset_done", done, 0);
            check("reset_busy", busy, 0);
            check("reset_bcd", bcd, 0);
            check("reset_neg", neg, 0);
            check("reset_ovf", ovf, 0);
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_latency", cyc, e.due);
                    check("bcd", bcd, e.bcd);
                    check("neg", neg, e.neg);
                    check("ovf", ovf, e.ovf);
                    held_bcd = e.bcd;
                    held_neg = e.neg;
                    held_ovf = e.ovf;
                end
            end else begin
                if (q.size() > 0 && cyc >= q[0].due) begin
                    check("missing_done", 0, 1);
                    void'(q.pop_front());
                end
                check("hold_bcd", bcd, held_bcd);
                check("hold_neg", neg, held_neg);
                check("hold_ovf", ovf, held_ovf);
            end
            check("busy", busy,
                  ((cyc >= last_acc && cyc <= last_acc + WIDTH) ||
                   (cyc >= prev_acc && cyc <= prev_acc + WIDTH)) ? 1 : 0);
        end
    end

    initial begin
        int base;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases.
        issue(32'd0);
        issue(32'd1234567);
        issue(32'hFFFF_FFD6);          // -42
        issue(32'h8000_0000);          // -2^31
        issue(32'd9999999);
        issue(32'd10000000);

        // Start held high: back-to-back, with the value changing during SHIFT.
        base = n_acc;
        while (n_acc < base + 3) begin
            if (n_acc == base)          drive(1'b1, 32'd9999999);
            else if (n_acc == base + 1) drive(1'b1, ((cyc + 1) >= next_free) ? 32'd10000000 : $urandom);
            else                        drive(1'b1, $urandom);
        end
        drive(1'b0, '0);
        while ((cyc + 1) < next_free) drive(1'b0, $urandom);

        // Reset mid-conversion, then a fresh conversion.
        drive(1'b1, 32'hFFFF_FFFF);
        repeat (9) drive(1'b0, $urandom);
        apply_reset(2);
        issue(32'd7654321);

        // Random traffic including edge values.
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] v;
            case ($urandom_range(0, 7))
                0:       v = 32'h8000_0000;
                1:       v = 32'hFFFF_FFFF;
                2:       v = 32'h7FFF_FFFF;
                3:       v = 32'd0;
                4:       v = $urandom_range(9_999_990, 10_000_010);
                5:       v = -($urandom_range(0, 20_000_000));
                default: v = $urandom;
            endcase
            drive($urandom_range(0, 3) == 0, v);
        end
        drive(1'b0, '0);

        // Drain with a bounded wait.
        for (int i = 0; i < 4 * WIDTH && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
